// File: rtl/vm_pkg.sv
// Shared types and helpers for the vending-machine credit path.
//   coin_code_t : 2-bit coin code as presented on the coin interface
//   acc_state_t : coin_accumulator state, also exported on its debug port
//   coin_value  : credit value of a coin code in units (0 for COIN_NONE)
package vm_pkg;

  localparam int BAL_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10,
    COIN_25   = 2'b11
  } coin_code_t;

  typedef enum logic [1:0] {
    ACC_IDLE   = 2'd0,
    ACC_CREDIT = 2'd1,
    ACC_PAYOUT = 2'd2
  } acc_state_t;

  // Five bits cover the largest coin, so callers of any balance width can
  // zero-extend the result.
  function automatic logic [4:0] coin_value(input coin_code_t code);
    case (code)
      COIN_5:  coin_value = 5'd5;
      COIN_10: coin_value = 5'd10;
      COIN_25: coin_value = 5'd25;
      default: coin_value = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/idle_timer.sv
// Inactivity counter for the credit state.
//   clk, rst : clock, asynchronous active-high reset
//   en       : count enable (high while credit is held)
//   clr      : activity seen this cycle, restart the count
//   expired  : count has reached TIMEOUT_CYC-1 (held until clr or !en)
module idle_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC);

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT_CYC - 1));

  // Leaving the enabled state also restarts the count, so every visit to
  // the credit state starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr || !en) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/coin_accumulator.sv
// Credit stage of the vending machine: credits coins, serves debit requests
// from the selection FSM and returns remaining credit as change.
//   coin_valid/coins          : coin strobe and code
//   coin_accept/coin_reject   : one-cycle result pulse, one cycle after the coin
//   deduct_req/deduct_amt     : debit request (level) and price
//   deduct_ack/deduct_nack    : one-cycle result pulse, one cycle after the take
//   refund_req                : customer cancel strobe
//   change_valid/amt/ready    : change output handshake
//   balance                   : registered credit
//   busy                      : paying out change, coins are refused
//   state                     : current FSM state (debug)
//
// Handshakes: change_amt is presented with change_valid and held unchanged
// until the edge where change_valid && change_ready, which completes the
// transfer. deduct_req is held by the requester until it sees deduct_ack or
// deduct_nack; the request is ignored during that pulse cycle so a requester
// that drops it on the following edge is never served twice.
module coin_accumulator
  import vm_pkg::*;
#(
  parameter int BAL_W       = BAL_W_DEFAULT,
  parameter int MAX_BAL     = 200,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coin_valid,
  input  logic [1:0]       coins,
  output logic             coin_accept,
  output logic             coin_reject,
  input  logic             deduct_req,
  input  logic [BAL_W-1:0] deduct_amt,
  output logic             deduct_ack,
  output logic             deduct_nack,
  input  logic             refund_req,
  output logic             change_valid,
  output logic [BAL_W-1:0] change_amt,
  input  logic             change_ready,
  output logic [BAL_W-1:0] balance,
  output logic             busy,
  output acc_state_t       state
);

  acc_state_t       state_nx;
  logic [BAL_W-1:0] bal_nx;
  logic [BAL_W-1:0] chg_amt_nx;
  logic [BAL_W-1:0] remain;
  logic [BAL_W:0]   coin_sum;
  logic             chg_valid_nx;
  logic             accept_nx;
  logic             reject_nx;
  logic             ack_nx;
  logic             nack_nx;
  logic             deduct_live;
  logic             deduct_ok;
  logic             coin_fits;
  logic             timer_expired;

  // Sum formed one bit wider than the balance so an overflowing coin is
  // detected instead of wrapping.
  assign coin_sum  = {1'b0, balance} +
                     {{(BAL_W - 4){1'b0}}, coin_value(coin_code_t'(coins))};
  assign coin_fits = (coin_code_t'(coins) != COIN_NONE) &&
                     (coin_sum <= (BAL_W + 1)'(MAX_BAL));

  assign deduct_live = deduct_req && !deduct_ack && !deduct_nack;
  assign deduct_ok   = (balance >= deduct_amt);
  assign remain      = balance - deduct_amt;
  assign busy        = (state == ACC_PAYOUT);

  idle_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (state == ACC_CREDIT),
    .clr    (deduct_req || refund_req || accept_nx),
    .expired(timer_expired)
  );

  // Same-edge priority: deduct, then refund, then coin, then timeout.
  always_comb begin
    state_nx     = state;
    bal_nx       = balance;
    chg_valid_nx = change_valid;
    chg_amt_nx   = change_amt;
    accept_nx    = 1'b0;
    reject_nx    = 1'b0;
    ack_nx       = 1'b0;
    nack_nx      = 1'b0;
    if (state == ACC_PAYOUT) begin
      nack_nx   = deduct_live;
      reject_nx = coin_valid;
      if (change_ready) begin
        state_nx     = ACC_IDLE;
        bal_nx       = '0;
        chg_valid_nx = 1'b0;
        chg_amt_nx   = '0;
      end
    end else if (deduct_live && deduct_ok) begin
      ack_nx    = 1'b1;
      reject_nx = coin_valid;
      bal_nx    = remain;
      // A refund on this edge is absorbed: any remainder is paid out anyway.
      if (remain != '0) begin
        state_nx     = ACC_PAYOUT;
        chg_valid_nx = 1'b1;
        chg_amt_nx   = remain;
      end else begin
        state_nx = ACC_IDLE;
      end
    end else begin
      nack_nx = deduct_live;
      if (refund_req && state == ACC_CREDIT) begin
        state_nx     = ACC_PAYOUT;
        chg_valid_nx = 1'b1;
        chg_amt_nx   = balance;
        reject_nx    = coin_valid;
      end else if (coin_valid && coin_fits) begin
        accept_nx = 1'b1;
        bal_nx    = coin_sum[BAL_W-1:0];
        state_nx  = ACC_CREDIT;
      end else begin
        reject_nx = coin_valid;
        // Any request this cycle counts as activity and defers the timeout.
        if (state == ACC_CREDIT && timer_expired && !deduct_req && !refund_req) begin
          state_nx     = ACC_PAYOUT;
          chg_valid_nx = 1'b1;
          chg_amt_nx   = balance;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ACC_IDLE;
      balance      <= '0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      coin_accept  <= 1'b0;
      coin_reject  <= 1'b0;
      deduct_ack   <= 1'b0;
      deduct_nack  <= 1'b0;
    end else begin
      state        <= state_nx;
      balance      <= bal_nx;
      change_valid <= chg_valid_nx;
      change_amt   <= chg_amt_nx;
      coin_accept  <= accept_nx;
      coin_reject  <= reject_nx;
      deduct_ack   <= ack_nx;
      deduct_nack  <= nack_nx;
    end
  end

endmodule
